// File: rtl/phase_a_seq_if.sv
// Handshake bundle between the phase_a sequencer and its requester / phase_a core.
interface phase_a_seq_if #(
  parameter int unsigned Size   = 3072,
  parameter int unsigned Iter_w = 6
);
  logic              start;
  logic [Size-1:0]   a_in;
  logic [Iter_w-1:0] iter;
  logic [Size-1:0]   pa_a;
  logic              pa_en;
  logic [Size-1:0]   pa_new_a;
  logic              pa_en_out;
  logic              busy;
  logic              done;
  logic [Size-1:0]   result;
  logic              err;

  // Requester / phase_a side: drives the request and the phase_a responses.
  modport master (
    output start, a_in, iter, pa_new_a, pa_en_out,
    input  pa_a, pa_en, busy, done, result, err
  );

  // Sequencer side.
  modport slave (
    input  start, a_in, iter, pa_new_a, pa_en_out,
    output pa_a, pa_en, busy, done, result, err
  );
endinterface

// File: rtl/phase_a_seq.sv
// Runs a phase_a unit iter times back to back, feeding each new_a into the next pass,
// with a per-pass watchdog that ends the sequence with err=1 on a stuck phase_a.
module phase_a_seq #(
  parameter int unsigned Size    = 3072,
  parameter int unsigned Iter_w  = 6,
  parameter int unsigned Timeout = 64
) (
  input logic          clk,
  input logic          rst,
  phase_a_seq_if.slave bus
);

  localparam int unsigned WdW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(Timeout - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StWait,
    StNext,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [Size-1:0]   pa_a_q, pa_a_d;
  logic [Size-1:0]   result_q, result_d;
  logic [Iter_w-1:0] rem_q, rem_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              launch_q, launch_d;  // set during the second LAUNCH cycle
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Next-state and datapath decisions; done defaults low so it only ever pulses.
  always_comb begin
    state_d  = state_q;
    pa_a_d   = pa_a_q;
    result_d = result_q;
    rem_d    = rem_q;
    wd_d     = wd_q;
    launch_d = launch_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      // FIN is the visible done cycle; busy is already low, so a new start is accepted there too.
      StIdle, StFin: begin
        if (state_q == StFin) begin
          state_d = StIdle;
        end
        if (bus.start) begin
          if (bus.iter != '0) begin
            pa_a_d  = bus.a_in;
            rem_d   = bus.iter;
            busy_d  = 1'b1;
            state_d = StLoad;
          end else begin
            result_d = bus.a_in;
            err_d    = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      StLoad: begin
        wd_d     = '0;
        launch_d = 1'b0;
        state_d  = StLaunch;
      end
      StLaunch: begin
        launch_d = 1'b1;
        if (launch_q) begin
          state_d = StWait;
        end
      end
      StWait: begin
        wd_d = wd_q + 1'b1;
        // Completion wins over a coincident timeout.
        if (bus.pa_en_out) begin
          pa_a_d  = bus.pa_new_a;
          rem_d   = rem_q - 1'b1;
          state_d = StNext;
        end else if (wd_q == WdLast) begin
          result_d = pa_a_q;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end
      StNext: begin
        if (rem_q != '0) begin
          state_d = StLoad;
        end else begin
          // Results are registered on the way into FIN so done is seen during FIN.
          result_d = pa_a_q;
          err_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StFin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pa_a_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      wd_q     <= '0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pa_a_q   <= pa_a_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      wd_q     <= wd_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.pa_a   = pa_a_q;
  assign bus.pa_en  = (state_q == StLaunch);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_phase_a_seq.sv
// Directed bench for phase_a_seq with a pass-level reference model and a phase_a responder.
module tb_phase_a_seq;

  localparam int unsigned SIZE = 64;
  localparam int unsigned ITW  = 6;
  localparam int unsigned TMO  = 24;

  logic clk;
  logic rst;

  phase_a_seq_if #(.Size(SIZE), .Iter_w(ITW)) bus ();

  phase_a_seq #(.Size(SIZE), .Iter_w(ITW), .Timeout(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;
  int done_cnt = 0;
  int en_rises = 0;
  bit en_prev  = 1'b0;

  // Reference model: pass-level view (pos 0 = load cycle, 1..2 = enable high,
  // 3.. = waiting, -1 = gap after a finished pass).
  bit          m_busy, m_done, m_err;
  int          m_pos, m_rem;
  logic [63:0] m_pa_a, m_result;

  // phase_a responder.
  bit          resp_on;
  int          resp_lat;
  logic [63:0] resp_delta;
  bit          trk;
  int          since;
  bit          prev_en;
  int          inj_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_pos = 0; m_rem = 0;
    m_pa_a = '0; m_result = '0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (!m_busy) begin
      if (bus.start) begin
        if (bus.iter != 0) begin
          m_busy = 1; m_pa_a = bus.a_in; m_rem = int'(bus.iter); m_pos = 0;
        end else begin
          m_result = bus.a_in; m_err = 0; m_done = 1;
        end
      end
    end else if (m_pos == -1) begin
      if (m_rem == 0) begin
        m_busy = 0; m_result = m_pa_a; m_err = 0; m_done = 1;
      end else begin
        m_pos = 0;
      end
    end else if (m_pos < 3) begin
      m_pos++;
    end else if (bus.pa_en_out) begin
      m_pa_a = bus.pa_new_a; m_rem--; m_pos = -1;
    end else if (m_pos - 3 == int'(TMO) - 1) begin
      m_busy = 0; m_result = m_pa_a; m_err = 1; m_done = 1;
    end else begin
      m_pos++;
    end
  endtask

  task automatic compare_all();
    check("pa_a", bus.pa_a, m_pa_a);
    check("pa_en", 64'(bus.pa_en), 64'(m_busy && (m_pos == 1 || m_pos == 2)));
    check("busy", 64'(bus.busy), 64'(m_busy));
    check("done", 64'(bus.done), 64'(m_done));
    check("result", bus.result, m_result);
    check("err", 64'(bus.err), 64'(m_err));
    if (bus.done === 1'b1) done_cnt++;
    if (bus.pa_en === 1'b1 && !en_prev) en_rises++;
    en_prev = (bus.pa_en === 1'b1);
  endtask

  task automatic responder_step();
    bus.pa_en_out = 1'b0;
    if (rst) begin
      trk = 0;
    end else begin
      if (bus.pa_en && !prev_en) begin
        trk = 1; since = 0;
      end else if (trk) begin
        since++;
      end
      if (trk && resp_on && since == resp_lat) begin
        bus.pa_en_out = 1'b1;
        bus.pa_new_a  = bus.pa_a + resp_delta;
        trk = 0;
      end
    end
    prev_en = bus.pa_en;
    if (cyc == inj_cyc) begin
      bus.pa_en_out = 1'b1;
      bus.pa_new_a  = 64'hDEAD_BEEF;
    end
  endtask

  // One clock: model sees inputs at the edge, outputs are compared 1 unit later,
  // new stimulus is applied 2 units after the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_step();
    #1;
    compare_all();
    #1;
    responder_step();
  endtask

  task automatic do_start(input logic [63:0] a, input int it);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.iter  = ITW'(it);
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic [63:0] res, output logic e,
                           output logic b, output int lat);
    int n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    res = bus.result;
    e   = bus.err;
    b   = bus.busy;
    lat = cyc - start_cyc + 1;
  endtask

  task automatic set_resp(input bit on, input int lat, input logic [63:0] d);
    resp_on = on; resp_lat = lat; resp_delta = d;
  endtask

  logic [63:0] res, res_clean;
  logic        e, b;
  int          lat, r0, d0;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.a_in = '0; bus.iter = '0;
    bus.pa_new_a = '0; bus.pa_en_out = 1'b0;
    set_resp(1, 17, 64'd1);
    trk = 0; since = 0; prev_en = 0;
    model_reset();

    // Reset state.
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_pa_a", bus.pa_a, 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);

    // iter=0, started on the very first edge after reset release.
    rst = 1'b0;
    r0 = en_rises;
    do_start(64'h5A, 0);
    wait_done("it0", res, e, b, lat);
    check("it0_result", res, 64'h5A);
    check("it0_err", 64'(e), 64'd0);
    check("it0_lat", 64'(lat), 64'd2);
    check("it0_busy", 64'(b), 64'd0);
    check("it0_no_pa_en", 64'(en_rises - r0), 64'd0);
    tick(); tick();

    // iter=3, L=17, a+1 per pass.
    set_resp(1, 17, 64'd1);
    r0 = en_rises;
    do_start(64'h1234, 3);
    wait_done("it3", res, e, b, lat);
    check("it3_result", res, 64'h1237);
    check("it3_err", 64'(e), 64'd0);
    check("it3_lat", 64'(lat), 64'd62);
    check("it3_rises", 64'(en_rises - r0), 64'd3);
    tick(); tick();

    // iter=2, phase_a never answers: timeout after TMO waiting cycles.
    set_resp(0, 0, 64'd0);
    r0 = en_rises;
    do_start(64'hABC, 2);
    wait_done("tmo", res, e, b, lat);
    check("tmo_result", res, 64'hABC);
    check("tmo_err", 64'(e), 64'd1);
    check("tmo_busy", 64'(b), 64'd0);
    check("tmo_lat", 64'(lat), 64'(TMO + 5));
    check("tmo_rises", 64'(en_rises - r0), 64'd1);
    tick(); tick();

    // Clean reference run, then the same run with a spurious pa_en_out in LOAD
    // and a second start during WAIT.
    set_resp(1, 5, 64'd7);
    do_start(64'h1000, 2);
    wait_done("clean", res_clean, e, b, lat);
    check("clean_result", res_clean, 64'h100E);
    check("clean_lat", 64'(lat), 64'd18);
    tick(); tick();
    inj_cyc = cyc + 1;
    do_start(64'h1000, 2);
    tick(); tick(); tick();
    bus.start = 1'b1; bus.a_in = 64'hFFFF; bus.iter = ITW'(1);
    tick();
    bus.start = 1'b0;
    wait_done("noise", res, e, b, lat);
    check("noise_result", res, res_clean);
    check("noise_err", 64'(e), 64'd0);
    check("noise_lat", 64'(lat), 64'd18);
    tick(); tick();

    // Reset during the second WAIT of an iter=4 run, then a late pa_en_out.
    set_resp(1, 6, 64'd1);
    do_start(64'h200, 4);
    for (int i = 0; i < 13; i++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    inj_cyc = cyc + 1;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_result", bus.result, 64'd0);
    check("abort_pa_a", bus.pa_a, 64'd0);
    check("abort_pa_en", 64'(bus.pa_en), 64'd0);
    do_start(64'h300, 1);
    wait_done("after_rst", res, e, b, lat);
    check("after_rst_result", res, 64'h301);
    check("after_rst_lat", 64'(lat), 64'd11);
    tick(); tick();

    // pa_en_out on the timeout cycle counts as completion.
    set_resp(1, TMO + 1, 64'd3);
    do_start(64'h40, 1);
    wait_done("edge", res, e, b, lat);
    check("edge_result", res, 64'h43);
    check("edge_err", 64'(e), 64'd0);
    check("edge_lat", 64'(lat), 64'(TMO + 6));
    tick(); tick();

    // One cycle later it is a timeout.
    set_resp(1, TMO + 2, 64'd3);
    do_start(64'h40, 1);
    wait_done("late", res, e, b, lat);
    check("late_result", res, 64'h40);
    check("late_err", 64'(e), 64'd1);
    check("late_lat", 64'(lat), 64'(TMO + 5));
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_a_seq.md
PHASE_A_SEQ -- requirements
Module: phase_a_seq

Interface
REQ-001 SHALL have parameter Size, default 3072, operand width in bits.
REQ-002 SHALL have parameter Iter_w, default 6, width of the iteration count.
REQ-003 SHALL have parameter Timeout, default 64, maximum cycles allowed per phase_a pass.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a sequence.
REQ-008 SHALL have port a_in, input, Size bits: initial operand.
REQ-009 SHALL have port iter, input, Iter_w bits: number of phase_a passes to run.
REQ-010 SHALL have port pa_a, output, Size bits: operand presented to phase_a input a.
REQ-011 SHALL have port pa_en, output, 1 bit: level enable to phase_a en.
REQ-012 SHALL have port pa_new_a, input, Size bits: phase_a new_a.
REQ-013 SHALL have port pa_en_out, input, 1 bit: phase_a en_out, the completion pulse.
REQ-014 SHALL have port busy, output, 1 bit: sequence in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port result, output, Size bits: final operand, held until the next done.
REQ-017 SHALL have port err, output, 1 bit: timeout flag, valid with done.

Function
REQ-018 SHALL implement the states IDLE, LOAD, LAUNCH, WAIT, NEXT and FIN.
REQ-019 On start in IDLE with iter!=0, SHALL, at the next edge:
- latch a_in into pa_a;
- latch iter into the remaining-pass counter rem;
- set busy=1;
- enter LOAD.
REQ-020 On start in IDLE with iter==0, SHALL at the next edge set result=a_in and err=0, pulse done, keep busy at 0, and stay in IDLE.
REQ-021 LOAD SHALL last 1 cycle with pa_en=0, then enter LAUNCH.
REQ-022 LAUNCH SHALL drive pa_en=1 for exactly 2 cycles, then enter WAIT.
REQ-023 WAIT SHALL drive pa_en=0 and increment the watchdog counter wd each cycle; wd is cleared on entry to LAUNCH.
REQ-024 In WAIT, on pa_en_out=1 SHALL load pa_new_a into pa_a, decrement rem, and enter NEXT.
REQ-025 NEXT SHALL last 1 cycle, then go to LOAD if rem!=0, otherwise to FIN.
REQ-026 FIN SHALL, in 1 cycle:
- set result=pa_a;
- set err=0;
- pulse done;
- clear busy;
- return to IDLE.
REQ-027 If wd reaches Timeout-1 in WAIT without pa_en_out, SHALL set result=pa_a (the last good operand) and err=1, pulse done, clear busy, and return to IDLE.
REQ-028 pa_en_out outside WAIT SHALL be ignored.
REQ-029 start while busy=1 SHALL be ignored; the sequence in progress is unaffected.
REQ-030 pa_en_out and timeout in the same WAIT cycle SHALL resolve as completion, not as error.
REQ-031 pa_en low time between consecutive rising edges SHALL be at least 3 cycles, which LOAD+NEXT+WAIT guarantee; pa_a SHALL be stable from LOAD until leaving WAIT.
REQ-032 Cycle count per sequence with phase_a latency L cycles (LAUNCH first cycle to pa_en_out) SHALL be 1 + iter*(L+3) + 1 cycles from start to done inclusive.
REQ-033 rem SHALL NOT wrap: NEXT with rem==0 SHALL go to FIN.

Reset
REQ-034 On rst=1, asynchronously and independent of clk, SHALL set:
- state=IDLE;
- pa_en=0, busy=0, done=0, err=0;
- pa_a=0, result=0, rem=0, wd=0.
REQ-035 Reset mid-sequence SHALL abort with no done pulse, and a pa_en_out arriving after reset SHALL be ignored.
REQ-036 The first start after rst deasserts SHALL be honoured on the first clk edge.

Verification
REQ-037 SHALL cover: iter=0, start with a_in=0x5A (zero-extended) -> done 1 cycle later, result=0x5A, err=0, pa_en never high.
REQ-038 SHALL cover: iter=3, phase_a model returning a+1 with L=17 -> exactly 3 pa_en rising edges, result=a_in+3, done at cycle 1+3*20+1=62, err=0.
REQ-039 SHALL cover: iter=2, model never pulses pa_en_out -> done with err=1 after Timeout cycles in WAIT, result=a_in, busy=0.
REQ-040 SHALL cover: start re-pulsed during WAIT, plus a spurious pa_en_out during LOAD -> both ignored, and result matches the run without them.
REQ-041 SHALL cover: rst asserted in the second WAIT of iter=4, then a pa_en_out -> no done, all outputs 0; a new start with iter=1 completes normally.
REQ-042 SHALL cover: pa_en_out coincident with the timeout cycle -> err=0, and result=pa_new_a at the last pass.
